// File: rtl/uart_pkg.sv
// uart_pkg: shared UART framing constants and FSM state encoding for transmitter and receiver.
package uart_pkg;
   localparam int DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: counts clocks within one serial bit and pulses bit_done on the last clock of the bit.
module uart_bit_timer #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_done
);
   localparam int W = $clog2(CLKS_PER_BIT);
   logic [W-1:0] clk_cnt;
   assign bit_done = clk_cnt == W'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) clk_cnt <= '0;
      else clk_cnt <= (clear || bit_done) ? '0 : clk_cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 LSB-first serialiser with a one-entry holding register.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
import uart_pkg::*;
module uart_transmitter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       txclk,
   input  logic       reset,
   input  logic       txen,
   input  logic       txld,
   input  logic [7:0] txdata,
   output logic       txout,
   output logic       txempty,
   output logic       txbusy
);
`ifdef UART_TX_PARITY_EN
   localparam state_t LAST = PARITY;
`else
   localparam state_t LAST = STOP;
`endif
   state_t state, state_n;
   logic [DATA_BITS-1:0] hold, shift, shift_n;
   logic [2:0] bit_cnt, bit_cnt_n;
   logic hold_full, hold_full_n, txout_n, load, xfer, bit_done;
`ifdef UART_TX_PARITY_EN
   logic par;
`endif
   // The timer idles at zero so a transfer out of IDLE starts a full-length start bit.
   uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
      .clk(txclk),
      .rst(reset),
      .clear(state == IDLE),
      .bit_done(bit_done)
   );
   assign load = txld && !hold_full;
   assign txempty = !hold_full;
   assign txbusy = state != IDLE;
   always_ff @(posedge txclk or posedge reset)
      if (reset) begin
         state <= IDLE;
         shift <= '0;
         hold <= '0;
         bit_cnt <= '0;
         hold_full <= 1'b0;
         txout <= LINE_IDLE;
      end else begin
         state <= state_n;
         shift <= shift_n;
         bit_cnt <= bit_cnt_n;
         hold_full <= hold_full_n;
         txout <= txout_n;
         if (load) hold <= txdata;
      end
`ifdef UART_TX_PARITY_EN
   always_ff @(posedge txclk or posedge reset)
      if (reset) par <= 1'b0;
      else if (xfer) par <= ^hold;
`endif
   always_comb begin
      state_n = state;
      shift_n = shift;
      bit_cnt_n = bit_cnt;
      xfer = 1'b0;
      case (state)
         IDLE: xfer = hold_full && txen;
         START: if (bit_done) begin
            state_n = DATA;
            bit_cnt_n = '0;
         end
         DATA: if (bit_done) begin
            if (bit_cnt == 3'(DATA_BITS - 1)) state_n = LAST;
            else begin
               bit_cnt_n = bit_cnt + 3'd1;
               shift_n = shift >> 1;
            end
         end
         STOP: if (bit_done) begin
            state_n = IDLE;
            xfer = hold_full && txen;
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_done) state_n = STOP;
`endif
         default: state_n = IDLE;
      endcase
      if (xfer) begin
         state_n = START;
         shift_n = hold;
      end
      // A load can only land while empty and a transfer only while full, so they never collide.
      hold_full_n = load || (hold_full && !xfer);
      txout_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : LINE_IDLE;
`ifdef UART_TX_PARITY_EN
      if (state_n == PARITY) txout_n = par;
`endif
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: randomized scoreboard bench for uart_transmitter (honours UART_TX_PARITY_EN).
module tb_uart_transmitter;
   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FL = NB * CPB;
   typedef struct {
      logic [7:0] data;
      int start;
   } exp_t;
   logic txclk = 1'b0, reset = 1'b1, txen = 1'b0, txld = 1'b0;
   logic [7:0] txdata = 8'h00;
   logic txout, txempty, txbusy;
   exp_t sb[$];
   exp_t e;
   int n_chk = 0, n_fail = 0, cyc = 0, m_last = -1000, k = 0, st = 0;
   logic m_full = 1'b0;
   logic [7:0] m_hold = 8'h00;
   bit in_frame = 1'b0;
   logic [43:0] samp = '0;
   uart_transmitter #(.CLKS_PER_BIT(CPB)) dut (
      .txclk(txclk),
      .reset(reset),
      .txen(txen),
      .txld(txld),
      .txdata(txdata),
      .txout(txout),
      .txempty(txempty),
      .txbusy(txbusy)
   );
   always #5 txclk = ~txclk;
   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // Line waveform of one frame, one sample per clock: start, data LSB first, [parity], stop.
   function automatic logic [43:0] frame_of(logic [7:0] d);
      logic [43:0] f = '0;
      for (int i = 0; i < FL; i++) begin
         int b = i / CPB;
         f[i] = b == 0 ? 1'b0 : b <= 8 ? d[b-1] : (NB == 11 && b == 9) ? ^d : 1'b1;
      end
      return f;
   endfunction
   // Reference model: a held byte leaves at any edge where txen is high and the last frame has run its full length.
   always @(posedge txclk) begin
      cyc++;
      if (reset) begin
         m_full = 1'b0;
         m_last = -1000;
         sb.delete();
      end else if (m_full && txen && cyc >= m_last + FL) begin
         sb.push_back('{m_hold, cyc});
         m_last = cyc;
         m_full = 1'b0;
      end else if (txld && !m_full) begin
         m_full = 1'b1;
         m_hold = txdata;
      end
   end
   always @(negedge txclk) begin
      if (reset) in_frame = 1'b0;
      else begin
         chk("txempty", txempty, !m_full);
         chk("txbusy", txbusy, (cyc - m_last) < FL);
         if (!in_frame && txout == 1'b0) begin
            in_frame = 1'b1;
            k = 0;
            st = cyc;
            samp = '0;
         end
         if (in_frame) begin
            samp[k] = txout;
            k++;
            if (k == FL) begin
               in_frame = 1'b0;
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL frame: unexpected frame %h starting cycle %0d, none required", samp, st);
               end else begin
                  e = sb.pop_front();
                  chk("frame bits", samp, frame_of(e.data));
                  chk("frame start", st, e.start);
               end
            end
         end
      end
   end
   task automatic tick(int n);
      repeat (n) @(negedge txclk);
   endtask
   task automatic send(logic [7:0] d);
      txdata = d;
      txld = 1'b1;
      tick(1);
      txld = 1'b0;
   endtask
   initial begin
      tick(3);
      chk("reset txout", txout, 1);
      chk("reset txempty", txempty, 1);
      chk("reset txbusy", txbusy, 0);
      reset = 1'b0;
      txen = 1'b1;
      tick(50);
      send(8'hA5);
      chk("full after load", txempty, 0);
      tick(1);
      chk("empty after transfer", txempty, 1);
      tick(FL + 5);
      send(8'h00);
      for (int i = 0; i < 100 && !txempty; i++) tick(1);
      chk("wait txempty", txempty, 1);
      send(8'hFF);
      tick(2 * FL + 5);
      send(8'h11);
      tick(2);
      send(8'h22);
      tick(3);
      send(8'h33);
      tick(2 * FL + 10);
      txen = 1'b0;
      send(8'h3C);
      tick(10);
      chk("gated txout", txout, 1);
      chk("gated txempty", txempty, 0);
      txen = 1'b1;
      tick(1);
      chk("gated start bit", txout, 0);
      tick(FL + 5);
      send(8'h07);
      tick(FL + 5);
      repeat (400) begin
         txen = $urandom_range(0, 7) != 0;
         txld = $urandom_range(0, 5) == 0;
         txdata = 8'($urandom);
         tick(1);
      end
      txld = 1'b0;
      txen = 1'b1;
      tick(2 * FL + 10);
      send(8'hC3);
      tick(18);
      #1 reset = 1'b1;
      #1;
      chk("async reset txout", txout, 1);
      chk("async reset txbusy", txbusy, 0);
      chk("async reset txempty", txempty, 1);
      tick(2);
      reset = 1'b0;
      tick(FL + 10);
      chk("post reset txempty", txempty, 1);
      chk("scoreboard drained", sb.size(), 0);
      chk("no open frame", in_frame, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Transmit side of the board-level serial link, paired with the receiver block on the same link. Same framing: 8N1, LSB first, line idles high.
- Accepts bytes through a one-entry holding register, then serialises them from a shift register onto txout.
- txclk runs at CLKS_PER_BIT times the baud rate. Bit timing is derived from an internal counter, so no baud-tick input exists.

Parameters:
- CLKS_PER_BIT, 16, txclk cycles per serial bit (must be >= 2).
- DATA_BITS, 8, data bits per frame (fixed at 8; present for package consistency).

Ports:
- txclk  input  1  transmit clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- txen  input  1  transmit enable; a new frame starts only while high.
- txld  input  1  load strobe; txdata is captured into the holding register when txempty=1.
- txdata  input  8  byte to transmit.
- txout  output  1  serial line, idle high.
- txempty  output  1  holding register empty; may load.
- txbusy  output  1  frame in progress (state != IDLE).

Behaviour:
- Reset (async, asserted at any time, including mid-frame):
  - txout=1, txempty=1, txbusy=0, state=IDLE, bit counter=0, clock counter=0, hold_full=0.
  - Any partial frame is abandoned immediately.
- Holding register:
  - txempty = ~hold_full.
  - At a rising edge with txld=1 and hold_full=0: capture txdata and set hold_full.
  - txld while hold_full=1 is ignored; data is lost and no error is flagged.
- State machine (IDLE, START, DATA, STOP). txout is registered.
  - IDLE: txout=1. If hold_full && txen: move the holding register into the shift register, clear hold_full, go to START, clk_cnt=0.
  - START: txout=0 for CLKS_PER_BIT cycles, then go to DATA with bit_cnt=0.
  - DATA: txout=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit 7 (bit_cnt==7 at clk_cnt==CLKS_PER_BIT-1), go to STOP.
  - STOP: txout=1 for CLKS_PER_BIT cycles. Then:
    - if hold_full && txen: transfer and go straight to START (back-to-back, no idle gap);
    - else go to IDLE.
- Latency: txld sampled at edge N in IDLE with txen=1 → transfer at edge N+1 → txout=0 from edge N+1.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Same edge as a transfer:
  - txld at the transfer edge is ignored, because hold_full is still 1 at that edge.
  - txempty rises after the transfer edge; a load on the following edge is accepted.
- txen dropped mid-frame: the current frame completes normally. The held byte stays held until txen returns high while the FSM is in IDLE or at the end of STOP.
- Counters:
  - clk_cnt is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT-1.
  - bit_cnt is 3 bits wide.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined:
  - a PARITY state is inserted between DATA and STOP;
  - txout = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles;
  - frame length is 11*CLKS_PER_BIT.
- When undefined: no PARITY state, no parity logic, 8N1 only.

Decomposition:
- Package uart_pkg:
  - state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4);
  - DATA_BITS;
  - line idle level constant.
  - The receiver adopts the same package.
- Sub-module uart_bit_timer:
  - clk_cnt with CLKS_PER_BIT wrap;
  - outputs bit_done pulse;
  - clear input driven by state transitions.
  - Reusable by the receiver.

Test Plan (all scenarios use CLKS_PER_BIT=4):
- Reset then idle: hold reset 3 cycles, txen=1, no txld → txout=1, txempty=1, txbusy=0 for 50 cycles.
- Single byte 0xA5: txld one cycle → txout = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles (40 cycles total); txempty=1 again one cycle after the load.
- Back-to-back 0x00 then 0xFF: second txld right after txempty rises → the 0xFF start bit immediately follows the 0x00 stop bit with no gap; txbusy stays high for 80 cycles.
- Overrun: load 0x11, then 0x22 (held), then 0x33 while full → frames 0x11 and 0x22 only; 0x33 is never sent.
- txen gating: load 0x3C with txen=0 → txout stays high and txempty=0; raise txen → start bit begins on the next edge.
- Reset mid-frame: assert reset during bit 3 of 0xC3 → txout=1 asynchronously; after release, no residual frame, txempty=1.
- Parity (with UART_TX_PARITY_EN defined): 0x07 → parity bit 1, frame of 44 cycles.
